// File: rtl/tape_recorder.sv
// rtl/tape_recorder.sv - Oric fast-format K7 tape decoder writing bytes to a buffer (option: TAPE_REC_PARITY_EN)
module tape_recorder #(
    parameter int MIN_PERIOD = 2000,
    parameter int BIT_THRESH = 15000,
    parameter int TIMEOUT    = 60000,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rewind,
    input  logic              en,
    input  logic              tape_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_we,
    output logic [ADDR_W:0]   rec_len,
    output logic              rec_full,
    output logic [7:0]        err_cnt,
    output logic              active
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] THR_C  = CNT_W'(BIT_THRESH);
    localparam logic [CNT_W-1:0] TMO_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        DATA   = 2'd2,
        PARITY = 2'd3
    } state_t;

    // Input synchroniser and edge history
    logic             sync1_q, sync2_q, prev_q;
    logic             rise;

    // Period measurement
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;

    // Per-cycle events from the period classifier
    logic             bit_vld;
    logic             bit_val;
    logic             tmo;

    // Frame decoder and buffer-side registers
    state_t           state_q;
    logic [2:0]       idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       mem_data_q;
    logic             mem_we_q;
    logic [ADDR_W:0]  rec_len_q;
    logic [7:0]       err_q;
    logic             full;

    // Two flops of metastability protection, a third to remember the previous level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= tape_out;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~prev_q;

    // Classify the rise-to-rise period into a bit, a glitch, or a carrier timeout
    always_comb begin
        cnt_d   = cnt_q;
        valid_d = valid_q;
        bit_vld = 1'b0;
        bit_val = 1'b0;
        tmo     = 1'b0;
        if (cnt_q != TMO_C) begin
            cnt_d = cnt_q + ONE_C;
        end
        if (rise) begin
            if (!valid_q) begin
                // First edge after reset or carrier loss only opens a period
                valid_d = 1'b1;
                cnt_d   = '0;
            end else if (cnt_q >= MIN_C) begin
                bit_vld = 1'b1;
                bit_val = (cnt_q < THR_C);
                cnt_d   = '0;
            end
            // Edges closer than MIN_PERIOD are glitches; the period keeps running
        end else if (cnt_q == TMO_M1) begin
            // Fires once, on the cycle the counter lands on its saturation value
            tmo     = 1'b1;
            valid_d = 1'b0;
        end
    end

    // Period counter and edge-valid flag
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign full = rec_len_q[ADDR_W];

`ifdef TAPE_REC_PARITY_EN
    logic parity_ok;
    // Odd parity over the eight data bits plus the parity bit
    assign parity_ok = ^{shift_q, bit_val};
`endif

    // Frame decoder, write strobe, length and error bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            shift_q    <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
            rec_len_q  <= '0;
            err_q      <= '0;
        end else begin
            mem_we_q <= 1'b0;
            if (mem_we_q) begin
                rec_len_q <= rec_len_q + {{ADDR_W{1'b0}}, 1'b1};
            end

            if (!en) begin
                // Relay off: any partial byte is abandoned without complaint
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= HUNT;
                    end
                    HUNT: begin
                        if (bit_vld && !bit_val) begin
                            state_q <= DATA;
                            idx_q   <= '0;
                        end
                    end
                    DATA: begin
                        if (tmo) begin
                            if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                            state_q <= HUNT;
                        end else if (bit_vld) begin
                            shift_q <= {bit_val, shift_q[7:1]};
                            idx_q   <= idx_q + 3'd1;
                            if (idx_q == 3'd7) state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        if (tmo) begin
                            if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                            state_q <= HUNT;
                        end else if (bit_vld) begin
                            state_q <= HUNT;
`ifdef TAPE_REC_PARITY_EN
                            if (!parity_ok) begin
                                if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                            end else if (!full) begin
                                mem_we_q   <= 1'b1;
                                mem_data_q <= shift_q;
                            end
`else
                            if (!full) begin
                                mem_we_q   <= 1'b1;
                                mem_data_q <= shift_q;
                            end
`endif
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end

            // Rewind overrides any same-cycle increment; a strobe already out keeps its old address
            if (rewind) begin
                rec_len_q <= '0;
                err_q     <= '0;
            end
        end
    end

    assign mem_addr = rec_len_q[ADDR_W-1:0];
    assign mem_data = mem_data_q;
    assign mem_we   = mem_we_q;
    assign rec_len  = rec_len_q;
    assign rec_full = full;
    assign err_cnt  = err_q;
    assign active   = (state_q != IDLE);

endmodule

// File: tb/tb_tape_recorder.sv
// tb/tb_tape_recorder.sv - directed/randomized bench for tape_recorder with a frame-level reference model
module tb_tape_recorder;

    localparam int AW   = 4;
    localparam int MINP = 10;
    localparam int THR  = 75;
    localparam int TMO  = 300;
    localparam int GAP  = 340;

`ifdef TAPE_REC_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rewind = 1'b0;
    logic          en = 1'b0;
    logic          tape_out = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_we;
    logic [AW:0]   rec_len;
    logic          rec_full;
    logic [7:0]    err_cnt;
    logic          active;

    int tests = 0;
    int fails = 0;

    // Reference model state: buffer length, error count, expected writes
    int         m_len = 0;
    int         m_err = 0;
    logic [AW-1:0] exp_addr[$];
    logic [7:0]    exp_data[$];
    logic [AW-1:0] obs_addr[$];
    logic [7:0]    obs_data[$];

    tape_recorder #(
        .MIN_PERIOD(MINP),
        .BIT_THRESH(THR),
        .TIMEOUT   (TMO),
        .ADDR_W    (AW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rewind  (rewind),
        .en      (en),
        .tape_out(tape_out),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_we  (mem_we),
        .rec_len (rec_len),
        .rec_full(rec_full),
        .err_cnt (err_cnt),
        .active  (active)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && mem_we) begin
            obs_addr.push_back(mem_addr);
            obs_data.push_back(mem_data);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One square-wave period starting with a rising edge; optional glitch just after the edge
    task automatic period(input int p, input bit glitch);
        tape_out = 1'b1;
        if (glitch) begin
            tick(2);
            tape_out = 1'b0;
            tick(3);
            tape_out = 1'b1;
            tick(p / 2 - 5);
        end else begin
            tick(p / 2);
        end
        tape_out = 1'b0;
        tick(p - p / 2);
    endtask

    task automatic bitp(input bit b, input bit g);
        period(b ? $urandom_range(40, 60) : $urandom_range(90, 110), g);
    endtask

    // Leader, start, 8 data LSB-first, parity, stop bits, closing edge, silent gap.
    // cut >= 0 stops the carrier before data bit 'cut' with the line held low.
    task automatic send_frame(input logic [7:0] d, input bit par, input int cut, input bit g);
        for (int i = 0; i < 5; i++) bitp(1'b1, g);
        bitp(1'b0, g);
        for (int i = 0; i < 8; i++) begin
            if (cut >= 0 && i == cut) return;
            bitp(d[i], g);
        end
        bitp(par, g);
        for (int i = 0; i < 4; i++) bitp(1'b1, g);
        tape_out = 1'b1;
        tick(20);
        tape_out = 1'b0;
        tick(GAP);
    endtask

    // Frame-level rule: odd parity over data+parity; a full buffer drops the byte
    task automatic model_frame(input logic [7:0] d, input bit par);
        bit ok;
        ok = ((($countones(d) + int'(par)) % 2) == 1);
        if (PAR_EN && !ok) begin
            if (m_err < 255) m_err++;
        end else if (m_len < (1 << AW)) begin
            exp_addr.push_back(AW'(m_len));
            exp_data.push_back(d);
            m_len++;
        end
    endtask

    task automatic frame(input logic [7:0] d, input bit par, input bit g);
        send_frame(d, par, -1, g);
        model_frame(d, par);
    endtask

    function automatic bit odd_par(input logic [7:0] d);
        return ~(^d);
    endfunction

    task automatic cmp_writes(input string tag);
        chk({tag, "_nwr"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 32'(obs_addr[i]), 32'(exp_addr[i]));
            chk($sformatf("%s_data%0d", tag, i), 32'(obs_data[i]), 32'(exp_data[i]));
        end
        obs_addr.delete();
        obs_data.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic cmp_status(input string tag);
        chk({tag, "_len"},  32'(rec_len),  32'(m_len));
        chk({tag, "_err"},  32'(err_cnt),  32'(m_err));
        chk({tag, "_full"}, 32'(rec_full), 32'(m_len == (1 << AW)));
    endtask

    task automatic cmp_all_zero(input string tag);
        chk({tag, "_addr"},   32'(mem_addr), 32'd0);
        chk({tag, "_data"},   32'(mem_data), 32'd0);
        chk({tag, "_we"},     32'(mem_we),   32'd0);
        chk({tag, "_len"},    32'(rec_len),  32'd0);
        chk({tag, "_full"},   32'(rec_full), 32'd0);
        chk({tag, "_err"},    32'(err_cnt),  32'd0);
        chk({tag, "_active"}, 32'(active),   32'd0);
    endtask

    initial begin
        logic [7:0] d;
        bit         p;

        // Reset state
        tick(4);
        reset = 1'b0;
        tick(1);
        cmp_all_zero("reset");

        en = 1'b1;
        tick(2);
        chk("en_active", 32'(active), 32'd1);
        tick(TMO + 20);

        // Leader plus 0x16, parity 0
        frame(8'h16, 1'b0, 1'b0);
        cmp_writes("b16");
        cmp_status("b16");

        // Bad parity on 0x16
        frame(8'h16, 1'b1, 1'b0);
        cmp_writes("par");
        cmp_status("par");

        // Random bytes, random parity, random glitches
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            p = 1'($urandom_range(0, 1));
            frame(d, p, 1'($urandom_range(0, 1)));
        end
        cmp_writes("rnd");
        cmp_status("rnd");

        // Glitches on every period, known byte
        frame(8'h5C, odd_par(8'h5C), 1'b1);
        cmp_writes("glt");

        // Carrier lost after the 4th data bit
        send_frame(8'h3B, 1'b0, 4, 1'b0);
        tick(TMO + 50);
        if (m_err < 255) m_err++;
        cmp_writes("tmo");
        cmp_status("tmo");
        frame(8'h24, odd_par(8'h24), 1'b0);
        cmp_writes("b24");
        cmp_status("b24");

        // Relay drop mid-byte
        send_frame(8'($urandom), 1'b0, 3, 1'b0);
        chk("drop_active_pre", 32'(active), 32'd1);
        en = 1'b0;
        tick(1);
        chk("drop_active", 32'(active), 32'd0);
        tick(GAP);
        en = 1'b1;
        tick(3);
        cmp_writes("drop");
        cmp_status("drop");
        frame(8'hA5, odd_par(8'hA5), 1'b0);
        cmp_writes("bA5");
        cmp_status("bA5");

        // Fill the buffer from address 0 with 17 bytes
        rewind = 1'b1;
        tick(1);
        rewind = 1'b0;
        m_len = 0;
        m_err = 0;
        tick(1);
        cmp_status("rew0");
        for (int i = 0; i < 17; i++) begin
            d = 8'($urandom);
            frame(d, odd_par(d), 1'b0);
        end
        cmp_writes("fill");
        cmp_status("fill");

        rewind = 1'b1;
        tick(1);
        rewind = 1'b0;
        m_len = 0;
        m_err = 0;
        tick(1);
        cmp_status("rew1");
        d = 8'($urandom);
        frame(d, odd_par(d), 1'b0);
        cmp_writes("after_rew");
        cmp_status("after_rew");

        // Build up a nonzero error count, then reset in the middle of DATA
        send_frame(8'h99, 1'b0, 4, 1'b0);
        tick(TMO + 50);
        if (m_err < 255) m_err++;
        cmp_status("pre_rst");
        send_frame(8'h77, 1'b0, 4, 1'b0);
        reset = 1'b1;
        tick(1);
        cmp_all_zero("mid_rst");
        reset = 1'b0;
        m_len = 0;
        m_err = 0;
        obs_addr.delete();
        obs_data.delete();
        exp_addr.delete();
        exp_data.delete();
        // First edge lands ~100 cycles after reset: a 0-length period if edge-valid were kept
        tick(100);
        frame(8'hC3, odd_par(8'hC3), 1'b0);
        cmp_writes("post_rst");
        cmp_status("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
